// File: rtl/seq_stream_gen_if.sv
// seq_stream_gen_if -- command and stream bundle for seq_stream_gen.
//   Command : i_start, i_len, i_init, i_step  (requester -> generator)
//   Stream  : o_valid, o_data, o_last         (generator -> sink), i_ready (sink -> generator)
//   Status  : o_busy, o_done                  (generator -> requester)
// Modport master is the generator side; modport slave is the requester/sink side.
interface seq_stream_gen_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 8
);
   logic                  i_start;
   logic [LEN_WIDTH-1:0]  i_len;
   logic [DATA_WIDTH-1:0] i_init;
   logic [DATA_WIDTH-1:0] i_step;
   logic                  i_ready;
   logic                  o_valid;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_last;
   logic                  o_busy;
   logic                  o_done;

   modport master (
      input  i_start, i_len, i_init, i_step, i_ready,
      output o_valid, o_data, o_last, o_busy, o_done
   );

   modport slave (
      output i_start, i_len, i_init, i_step, i_ready,
      input  o_valid, o_data, o_last, o_busy, o_done
   );
endinterface

// File: rtl/seq_stream_gen.sv
// seq_stream_gen -- arithmetic-sequence burst generator.
//   i_clk       : single clock, rising edge
//   i_async_rst : asynchronous, active-high reset
//   bus         : seq_stream_gen_if.master; a start in IDLE latches len/init/step,
//                 then len beats (init + k*step, wrapping) are streamed with a
//                 valid/ready handshake, o_last on the final beat, followed by a
//                 one-cycle o_done pulse. o_busy is high outside IDLE.
module seq_stream_gen #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic             i_clk,
   input  logic             i_async_rst,
   seq_stream_gen_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] step_q, step_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last;

   // Counter only ever reaches len-1, so a full-scale len cannot overflow it.
   assign last = (state_q == ST_RUN) && (cnt_q == (len_q - LEN_WIDTH'(1)));

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               len_d   = bus.i_len;
               step_d  = bus.i_step;
               data_d  = bus.i_init;
               cnt_d   = '0;
               state_d = (bus.i_len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (bus.i_ready) begin
               if (last) begin
                  state_d = ST_DONE;
               end else begin
                  // Running accumulator: data tracks init + cnt*step modulo 2^DATA_WIDTH.
                  cnt_d  = cnt_q + LEN_WIDTH'(1);
                  data_d = data_q + step_q;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_async_rst) begin
      if (i_async_rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         step_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         data_q  <= data_d;
      end
   end

   assign bus.o_valid = (state_q == ST_RUN);
   assign bus.o_data  = data_q;
   assign bus.o_last  = last;
   assign bus.o_busy  = (state_q != ST_IDLE);
   assign bus.o_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_stream_gen.sv
// tb_seq_stream_gen -- scoreboard bench for seq_stream_gen.
//   Stimulus pushes the expected beats (init + k*step) and a completion marker
//   for each accepted burst; a negedge monitor pops and compares on every
//   handshake and o_done pulse, and checks hold-while-stalled behaviour.
module tb_seq_stream_gen;
   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;

   typedef struct {
      bit            is_done;
      logic [DW-1:0] data;
      bit            last;
   } exp_t;

   logic i_clk;
   logic i_async_rst;
   int   errors;
   int   checks;
   int   ready_mode;
   exp_t sb[$];

   seq_stream_gen_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   seq_stream_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .i_clk       (i_clk),
      .i_async_rst (i_async_rst),
      .bus         (bus.master)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ready pattern: 0 = always high, 1 = alternating, 2 = coin flip, 3 = mostly high.
   always @(posedge i_clk) begin
      #1;
      case (ready_mode)
         0:       bus.i_ready = 1'b1;
         1:       bus.i_ready = ~bus.i_ready;
         2:       bus.i_ready = 1'($urandom_range(0, 1));
         default: bus.i_ready = (($urandom % 4) != 0);
      endcase
   end

   // Monitor
   logic          stall_prev;
   logic [DW-1:0] held_data;
   logic          held_last;
   always @(negedge i_clk) begin
      if (i_async_rst) begin
         stall_prev = 1'b0;
      end else begin
         if (bus.o_valid && !bus.o_busy) check("valid_implies_busy", 0, 1);
         if (stall_prev) begin
            check("stall_hold_data", bus.o_data, held_data);
            check("stall_hold_last", bus.o_last, held_last);
         end
         stall_prev = bus.o_valid && !bus.i_ready;
         held_data  = bus.o_data;
         held_last  = bus.o_last;
         if (bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", bus.o_data, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("beat_kind", 0, e.is_done);
               check("beat_data", bus.o_data, e.data);
               check("beat_last", bus.o_last, e.last);
            end
         end
         if (bus.o_done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("done_kind", 1, e.is_done);
               check("done_not_valid", bus.o_valid, 0);
            end
         end
      end
   end

   // Waits (posedge+1 aligned) until the DUT is idle, with a cycle budget.
   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while (bus.o_busy && n < 2000) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      if (bus.o_busy) check("idle_timeout", 1, 0);
   endtask

   // Issued at posedge+1 with the DUT idle; accepted on the next rising edge.
   task automatic start_burst(input logic [LW-1:0] len, input logic [DW-1:0] init,
                              input logic [DW-1:0] step);
      bus.i_start = 1'b1;
      bus.i_len   = len;
      bus.i_init  = init;
      bus.i_step  = step;
      for (int k = 0; k < int'(len); k++)
         sb.push_back('{0, DW'(int'(init) + k * int'(step)), (k == int'(len) - 1)});
      sb.push_back('{1, '0, 0});
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_len   = LW'($urandom);
      bus.i_init  = DW'($urandom);
      bus.i_step  = DW'($urandom);
      check("accept_busy", bus.o_busy, 1);
      check("accept_valid", bus.o_valid, (len != 0));
      check("accept_done", bus.o_done, (len == 0));
      if (len == 0) begin
         @(posedge i_clk);
         #1;
         check("zero_len_busy_drop", bus.o_busy, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      errors      = 0;
      checks      = 0;
      ready_mode  = 0;
      stall_prev  = 1'b0;
      bus.i_start = 1'b0;
      bus.i_len   = '0;
      bus.i_init  = '0;
      bus.i_step  = '0;
      bus.i_ready = 1'b1;
      i_async_rst = 1'b1;

      // Reset values, visible before any clock edge.
      #1;
      check("rst_valid", bus.o_valid, 0);
      check("rst_last", bus.o_last, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_data", bus.o_data, 0);

      // Release between edges; the first edge afterwards accepts the start.
      @(negedge i_clk);
      i_async_rst = 1'b0;
      start_burst(8'd4, 8'h10, 8'd1);
      wait_idle();

      ready_mode = 1;
      @(posedge i_clk); #1;
      start_burst(8'd3, 8'd5, 8'd2);
      wait_idle();

      ready_mode = 0;
      start_burst(8'd3, 8'hFE, 8'd1);
      wait_idle();

      start_burst(8'd0, 8'h33, 8'd7);
      wait_idle();

      // Start pulses during RUN with different params must be ignored.
      ready_mode = 1;
      start_burst(8'd6, 8'h40, 8'd3);
      @(posedge i_clk); #1;
      bus.i_start = 1'b1;
      bus.i_len   = 8'd2;
      bus.i_init  = 8'h99;
      bus.i_step  = 8'd9;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
      wait_idle();
      check("ignored_start_no_extra", sb.size(), 0);

      // Asynchronous reset during beat 2 of a len=5 burst.
      ready_mode = 0;
      start_burst(8'd5, 8'h20, 8'd4);
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      @(negedge i_clk); #2;
      i_async_rst = 1'b1;
      #1;
      check("async_rst_valid", bus.o_valid, 0);
      check("async_rst_busy", bus.o_busy, 0);
      check("async_rst_last", bus.o_last, 0);
      check("async_rst_data", bus.o_data, 0);
      sb.delete();
      @(posedge i_clk); #1;
      check("rst_hold_done", bus.o_done, 0);
      @(negedge i_clk); #1;
      i_async_rst = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("post_rst_idle", bus.o_busy, 0);
      start_burst(8'd5, 8'h20, 8'd4);
      wait_idle();

      // Randomised bursts.
      for (int n = 0; n < 24; n++) begin
         ready_mode = 2 + (n % 2);
         start_burst(LW'($urandom_range(0, 12)), DW'($urandom), DW'($urandom));
         wait_idle();
      end

      // Full-scale length.
      ready_mode = 3;
      start_burst(8'd255, DW'($urandom), DW'($urandom));
      wait_idle();

      repeat (5) @(posedge i_clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seq_stream_gen.md
SEQ_STREAM_GEN -- requirements
Module: seq_stream_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of generated data words.
REQ-002 Parameter LEN_WIDTH, default 8: width of the burst-length input and beat counter.
REQ-003 Port i_clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port i_async_rst  input  1: reset, asynchronous and active-high.
REQ-005 Port i_start  input  1: start-burst request, sampled at rising edge.
REQ-006 Port i_len  input  LEN_WIDTH: number of beats in the burst, unsigned.
REQ-007 Port i_init  input  DATA_WIDTH: first data value of the burst.
REQ-008 Port i_step  input  DATA_WIDTH: increment between consecutive beats, unsigned.
REQ-009 Port o_valid  output  1: downstream data valid.
REQ-010 Port i_ready  input  1: downstream ready.
REQ-011 Port o_data  output  DATA_WIDTH: current beat value.
REQ-012 Port o_last  output  1: current beat is the final beat of the burst.
REQ-013 Port o_busy  output  1: burst in progress (state RUN or DONE).
REQ-014 Port o_done  output  1: one-cycle pulse marking burst completion.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; all outputs registered or decoded from registered state only.
REQ-016 In IDLE, i_start=1 SHALL latch i_len, i_init, i_step and go to RUN if i_len!=0, else to DONE.
REQ-017 i_start SHALL be ignored in RUN and DONE; latched parameters SHALL not change mid-burst.
REQ-018 o_valid SHALL be 1 exactly while in RUN; first beat is visible the cycle after the accepting edge (latency 1).
REQ-019 Handshake: a beat transfers on a rising edge where o_valid=1 and i_ready=1.
REQ-020 While o_valid=1 and i_ready=0, o_data and o_last SHALL hold stable.
REQ-021 Beat k (0-based) SHALL carry o_data = (init + k*step) mod 2^DATA_WIDTH; wrap-around silent.
REQ-022 Beat counter counts transferred beats; o_last=1 iff in RUN and counter == len-1.
REQ-023 Transfer of the o_last beat SHALL move FSM to DONE; no extra beat SHALL be presented.
REQ-024 In DONE, o_done=1 for exactly one cycle, then FSM returns to IDLE unconditionally.
REQ-025 o_busy = (state != IDLE); a new i_start is accepted the first cycle back in IDLE.
REQ-026 i_len = 2^LEN_WIDTH-1 SHALL produce exactly that many beats; counter SHALL not overflow.
REQ-027 i_ready is allowed to toggle arbitrarily, including being 1 outside RUN; it has no effect outside RUN.

Reset
REQ-028 On i_async_rst=1, state SHALL become IDLE immediately without waiting for a clock edge.
REQ-029 Reset values: o_valid=0, o_last=0, o_busy=0, o_done=0, o_data=0, counter=0, latched params=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst; no o_done pulse SHALL follow reset release.
REQ-031 First i_start accepted on the first rising edge with i_async_rst=0.

Verification
REQ-032 Basic: len=4, init=0x10, step=1, i_ready=1 -> beats 0x10,0x11,0x12,0x13 on 4 consecutive cycles, o_last on 0x13, o_done 1 cycle later.
REQ-033 Backpressure: len=3, init=5, step=2, i_ready low every other cycle -> data 5,7,9 each held stable while stalled, exactly 3 transfers.
REQ-034 Wrap: DATA_WIDTH=8, len=3, init=0xFE, step=1 -> 0xFE,0xFF,0x00.
REQ-035 Zero length: len=0 start -> o_valid never asserted, o_done pulse the cycle after accept, o_busy high for that one cycle.
REQ-036 Start ignored: i_start pulsed during RUN with different params -> original burst unaffected, no second burst.
REQ-037 Async reset: assert i_async_rst between clock edges during beat 2 of len=5 -> o_valid/o_busy drop before next edge, no o_done, restart after release gives full fresh burst.
